// File: rtl/dbus_timer.sv
`default_nettype none
// ============================================================================
// Module      : dbus_timer
// Description : Data-bus responder interval timer with prescaler, compare
//               match, auto-reload and a registered level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1FD0_0100,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dbus_address,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wrdata,
    output logic [31:0] dbus_rddata,
    output logic        hit,
    output logic        timer_irq
);

    localparam logic [1:0]  c_REG_CTRL    = 2'd0;
    localparam logic [1:0]  c_REG_COUNT   = 2'd1;
    localparam logic [1:0]  c_REG_COMPARE = 2'd2;
    localparam logic [1:0]  c_REG_STATUS  = 2'd3;
    localparam logic [15:0] c_PS_LAST     = 16'(PRESCALE - 1);

    logic [2:0]  ctrl_q,    ctrl_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q,    pend_d;
    logic [15:0] ps_q,      ps_d;
    logic        irq_q,     irq_d;

    logic [1:0]  w_sel;
    logic        w_wr;
    logic        w_cnt_wr;
    logic        w_tick;
    logic        w_match;
    logic        w_unused_addr;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign hit           = (dbus_address[31:4] == BASE_ADDR[31:4]);
    assign w_sel         = dbus_address[3:2];
    assign w_wr          = dbus_write & hit;
    assign w_cnt_wr      = w_wr && (w_sel == c_REG_COUNT);
    assign w_tick        = ctrl_q[0] && (ps_q == c_PS_LAST);
    assign w_match       = w_tick && (count_q == compare_q);
    assign w_unused_addr = ^dbus_address[1:0];
    assign timer_irq     = irq_q;

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        pend_d    = pend_q;
        ps_d      = ps_q;

        if (w_tick) begin
            count_d = (w_match && ctrl_q[1]) ? 32'h0 : count_q + 32'd1;
        end

        // Bus writes are applied after the tick so a COUNT write wins.
        if (w_wr) begin
            case (w_sel)
                c_REG_CTRL:    if (dbus_byteenable[0]) ctrl_d = dbus_wrdata[2:0];
                c_REG_COUNT:   count_d   = merge_lanes(count_q, dbus_wrdata, dbus_byteenable);
                c_REG_COMPARE: compare_d = merge_lanes(compare_q, dbus_wrdata, dbus_byteenable);
                default:       if (dbus_byteenable[0] && dbus_wrdata[0]) pend_d = 1'b0;
            endcase
        end

        if (w_match) pend_d = 1'b1;

        // Gating on both old and new EN keeps the prescaler at 0 whenever idle.
        if (!ctrl_q[0] || !ctrl_d[0] || w_cnt_wr || w_tick) begin
            ps_d = 16'd0;
        end else begin
            ps_d = ps_q + 16'd1;
        end

        irq_d = pend_d & ctrl_d[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= 3'd0;
            count_q   <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
            pend_q    <= 1'b0;
            ps_q      <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
            ps_q      <= ps_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        dbus_rddata = 32'h0;
        if (dbus_read && hit) begin
            case (w_sel)
                c_REG_CTRL:    dbus_rddata = {29'd0, ctrl_q};
                c_REG_COUNT:   dbus_rddata = count_q;
                c_REG_COMPARE: dbus_rddata = compare_q;
                c_REG_STATUS:  dbus_rddata = {31'd0, pend_q};
                default:       dbus_rddata = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dbus_timer.md
# dbus_timer

Memory-mapped interval timer that sits on the CPU data bus as a responder (target) for `naive_mips` loads and stores. It decodes a 16-byte window at `BASE_ADDR`, services single-cycle reads and byte-enabled writes with no wait states, and counts prescaled clock ticks against a compare register. It raises a level interrupt that the top level routes into one bit of the CPU `hardware_int_in` vector.

## Interface

Parameters:

- `BASE_ADDR`, default 32'h1FD0_0100: window base. Bits [3:0] are ignored. The block decodes `dbus_address[31:4]`.
- `PRESCALE`, default 1: clock cycles per count tick. Legal range is 1..65536.

Ports:

- `clk` input 1: single clock. All state updates occur on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `dbus_address` input 32: byte address from the CPU.
- `dbus_byteenable` input 4: byte lane enables. Bit n enables bits [8n+7:8n].
- `dbus_read` input 1: read strobe.
- `dbus_write` input 1: write strobe.
- `dbus_wrdata` input 32: write data.
- `dbus_rddata` output 32: read data. Combinational.
- `hit` output 1: the address falls inside the window. The top level uses it to select the read-data source.
- `timer_irq` output 1: interrupt request, level, registered.

## Operation

- Address decode: `hit = (dbus_address[31:4] == BASE_ADDR[31:4])`. Register select is `dbus_address[3:2]`. Bits [1:0] are ignored.
- Register map:
  - 0x0 CTRL, R/W. bit0 EN: count enable. bit1 AR: auto-reload. bit2 IE: interrupt enable. Bits [31:3] read 0 and ignore writes.
  - 0x4 COUNT, R/W, 32 bits.
  - 0x8 COMPARE, R/W, 32 bits.
  - 0xC STATUS. bit0 PEND. Writing 1 to bit0 with byteenable[0] set clears PEND (W1C). Writing 0 has no effect. Bits [31:1] read 0.
- Writes: when `dbus_write & hit`, each enabled byte lane of the selected register is updated on the next rising edge. Disabled lanes hold their value.
- Reads: `dbus_rddata` shows the selected register's current (pre-edge) value whenever `dbus_read & hit`. Otherwise it is 32'h0, so the output is safe to OR into a bus mux.
- `dbus_read` and `dbus_write` both high with `hit`: the write is performed and the read returns the old value.
- Strobes with `hit` low: no state change.
- Prescaler: an internal counter runs 0..PRESCALE-1 while EN=1. `tick` is asserted in the cycle the counter equals PRESCALE-1, after which it wraps to 0. While EN=0, the prescaler holds at 0 and no ticks occur.
- Tick behaviour, evaluated on pre-edge values:
  - If COUNT == COMPARE: PEND <= 1. COUNT <= AR ? 0 : COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - All additions are modulo 2^32. 32'hFFFF_FFFF wraps to 0 with no flag.
- `timer_irq` is a flop loaded each edge with `PEND_next & IE_next`. Clearing IE deasserts it on the next edge while PEND stays set.

Priorities when events coincide in one cycle:

- A bus write to COUNT overrides the tick update of COUNT, including the auto-reload. The prescaler also resets to 0 that cycle.
- The match is evaluated with old COMPARE/COUNT. A write to COMPARE in the same cycle does not affect that cycle's match.
- Match set beats W1C clear: PEND stays 1.
- A write to CTRL clearing EN in a tick cycle: the tick still applies, then counting stops.

Reset (`rst` high, asynchronous, at any time including mid-count):

- CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, PEND=0, prescaler=0, `timer_irq`=0.
- `dbus_rddata` reads these values immediately.
- The block leaves reset on the first rising edge after `rst` falls.

## Timing

- Read latency is 0 cycles. Data is valid in the same cycle as `dbus_read`, and the MIPS memory stage samples it before the edge.
- Write latency is 1 edge. A read in the next cycle returns the new value.
- With PRESCALE=P and EN set at edge E0, the first tick occurs in the cycle ending at edge E0+P. COUNT increments once per P cycles.
- Match to `timer_irq`: PEND and `timer_irq` both rise on the tick edge where COUNT==COMPARE, i.e. 0 cycles after PEND, 1 edge after the matching value was present.
- The W1C write edge drops PEND and `timer_irq` together, unless a match occurs on the same edge.

## Test plan

- Reset values: assert `rst` asynchronously mid-cycle. `timer_irq`=0 immediately. Reads of 0x0/0x4/0x8/0xC return 0/0/FFFFFFFF/0.
- Byte lanes: write 0xAABBCCDD to COMPARE with byteenable 4'b0101 (from reset value FFFFFFFF). Readback = 0xFFBBFFDD. Access at BASE+0x10 gives `hit`=0, `dbus_rddata`=0 and no state change.
- One-shot: PRESCALE=1, COMPARE=5, CTRL=0b101. PEND and `timer_irq` rise on the edge where COUNT leaves 5. COUNT continues 6, 7, …. W1C to STATUS drops `timer_irq` next edge.
- Auto-reload with PRESCALE=4: COMPARE=2, CTRL=0b111. COUNT sequence 0,1,2,0,1,2 with each value held 4 cycles. PEND sets every 12 cycles. A W1C issued on the match edge leaves PEND=1.
- Write-vs-tick: a COUNT write of 0x100 in a tick cycle gives readback 0x100, not old+1. A COMPARE write in the match cycle still yields PEND=1 from the old COMPARE.
- Wrap and reset mid-operation: COUNT=FFFFFFFE, COMPARE=3, EN=1. COUNT goes to 0 with no PEND until COUNT=3. Pulsing `rst` during counting returns all registers to reset values immediately.
